// File: rtl/seg_scan_pkg.sv
// Shared constants, FSM state type and index-width helper for the 7-segment scan controller.
package seg_scan_pkg;

  localparam int   NIBBLE_W = 4;
  localparam logic AN_OFF   = 1'b1;
  localparam logic SEG_OFF  = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter for the scan controller: flags the end of the blanking phase and the end of each digit slot.
module seg_scan_timer #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_end,
  output logic blank_done
);

  localparam int            CW        = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] cnt;

  // Free-running slot counter, wrapping at the end of every digit slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign slot_end   = (cnt == LAST_CNT);
  assign blank_done = (cnt == BLANK_END);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           load,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  input  logic [NUM_DIGITS-1:0]          dp,
  output logic [NIBBLE_W-1:0]            bin,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic                           dp_n,
  output logic                           frame_tick
);

  localparam int                      IW       = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0]           LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0]           IDX_ONE  = IW'(1);
  localparam logic [NUM_DIGITS-1:0]   ALL_OFF  = {NUM_DIGITS{AN_OFF}};

  state_t                           state, state_nxt;
  logic [IW-1:0]                    idx, idx_nxt;
  logic [NIBBLE_W*NUM_DIGITS-1:0]   pending, pending_nxt;
  logic [NIBBLE_W*NUM_DIGITS-1:0]   active, active_nxt;
  logic [NIBBLE_W-1:0]              bin_nxt;
  logic [NUM_DIGITS-1:0]            an_nxt;
  logic                             dp_nxt;
  logic [NUM_DIGITS-1:0]            en_eff;
  logic                             slot_end, blank_done, frame_wrap;

  seg_scan_timer #(
    .DIGIT_CYCLES(DIGIT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_end  (slot_end),
    .blank_done(blank_done)
  );

  assign frame_wrap = slot_end && (idx == LAST_IDX);

`ifdef SEG_SCAN_LZ_BLANK_EN
  // A decimal point anchors its digit and everything below it against suppression.
  function automatic logic [NUM_DIGITS-1:0] lz_suppress(
    input logic [NIBBLE_W*NUM_DIGITS-1:0] v,
    input logic [NUM_DIGITS-1:0]          d
  );
    logic run;
    lz_suppress = '0;
    run         = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run            = run && (v[NIBBLE_W*i +: NIBBLE_W] == 4'h0) && !d[i];
      lz_suppress[i] = run;
    end
  endfunction

  localparam logic [NUM_DIGITS-1:0] LZ_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
  logic [NUM_DIGITS-1:0] lz_mask;

  // Suppression mask re-evaluated on the new active buffer at each frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lz_mask <= LZ_RESET;
    end else if (frame_wrap) begin
      lz_mask <= lz_suppress(active_nxt, dp);
    end else begin
      lz_mask <= lz_mask;
    end
  end

  assign en_eff = digit_en & ~lz_mask;
`else
  assign en_eff = digit_en;
`endif

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= '0;
      pending    <= '0;
      active     <= '0;
      bin        <= '0;
      an_n       <= ALL_OFF;
      dp_n       <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      active     <= active_nxt;
      bin        <= bin_nxt;
      an_n       <= an_nxt;
      dp_n       <= dp_nxt;
      frame_tick <= frame_wrap;
    end
  end

  // Next state, digit index and buffer update
  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (blank_done) state_nxt = DRIVE; else state_nxt = BLANK;
      DRIVE:   if (slot_end)   state_nxt = BLANK; else state_nxt = DRIVE;
      default: state_nxt = BLANK;
    endcase

    if (slot_end) begin
      idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
    end else begin
      idx_nxt = idx;
    end

    pending_nxt = load ? value : pending;
    // A load on the boundary edge bypasses pending so it shows in the frame just starting
    if (frame_wrap) begin
      active_nxt = load ? value : pending;
    end else begin
      active_nxt = active;
    end
  end

  // Next output values; bin latches at slot start so it settles during blanking
  always_comb begin
    if (slot_end) begin
      bin_nxt = active_nxt[idx_nxt*NIBBLE_W +: NIBBLE_W];
    end else begin
      bin_nxt = bin;
    end

    an_nxt = ALL_OFF;
    dp_nxt = SEG_OFF;
    if ((state_nxt == DRIVE) && en_eff[idx]) begin
      an_nxt[idx] = 1'b0;
      dp_nxt      = ~dp[idx];
    end else begin
      an_nxt = ALL_OFF;
      dp_nxt = SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = N * DC;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  bin;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: t counts cycles since the last reset edge
  int          t;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_en, m_dp;

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .dp        (dp),
    .bin       (bin),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    int       d;
    int       ph;
    logic     lit;
    logic [3:0] an_e;
    d    = (t / DC) % N;
    ph   = t % DC;
    lit  = (ph >= BC) && m_en[d];
    an_e = lit ? ~(4'b0001 << d) : 4'b1111;
    chk("bin", {12'h000, bin}, {12'h000, m_act[d*4 +: 4]});
    chk("an_n", {12'h000, an_n}, {12'h000, an_e});
    chk("dp_n", {15'h0000, dp_n}, {15'h0000, ~(lit && m_dp[d])});
    chk("frame_tick", {15'h0000, frame_tick}, {15'h0000, (t != 0) && (t % FRAME == 0)});
    chk("an_onehot", 16'($countones(~an_n) <= 1), 16'h0001);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic cycle(input logic r, input logic ld, input logic [15:0] v,
                       input logic [3:0] en, input logic [3:0] d);
    rst_n    = r;
    load     = ld;
    value    = v;
    digit_en = en;
    dp       = d;
    if (!r) begin
      t      = 0;
      m_act  = 16'h0000;
      m_pend = 16'h0000;
    end else begin
      t = t + 1;
      if (ld) m_pend = v;
      if (t % FRAME == 0) m_act = m_pend;
    end
    m_en = en;
    m_dp = d;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic       found;
    logic [3:0] ren, rdp;
    t = 0; m_act = 16'h0000; m_pend = 16'h0000; m_en = 4'hF; m_dp = 4'h0;

    // Reset held three cycles, then idle scan of the zero buffer
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);

    // Scan order with 1A2F
    cycle(1'b1, 1'b1, 16'h1A2F, 4'hF, 4'h0);
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);

    // Mid-frame load waits for the boundary
    cycle(1'b1, 1'b1, 16'h1234, 4'hF, 4'h0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);

    // Load exactly on the boundary edge shows in the new frame
    for (int i = 0; i < FRAME && ((t + 1) % FRAME != 0); i++)
      cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);
    cycle(1'b1, 1'b1, 16'h5678, 4'hF, 4'h0);
    chk("boundary_load_bin", {12'h000, bin}, 16'h0008);
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);

    // Partial enables and decimal point
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0, 16'h0000, 4'b0101, 4'b0100);

    // Randomized loads, enables and decimal points; several loads per frame
    ren = 4'hF; rdp = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) ren = 4'($urandom);
      if ($urandom_range(19) == 0) rdp = 4'($urandom);
      cycle(1'b1, ($urandom_range(11) == 0), 16'($urandom), ren, rdp);
    end

    // Reset while digit 2 is being driven
    cycle(1'b1, 1'b1, 16'hBEEF, 4'hF, 4'h0);
    for (int i = 0; i < FRAME + 1; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (an_n == 4'b1011) found = 1'b1;
      else cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);
    end
    chk("found_digit2_drive", {15'h0000, found}, 16'h0001);
    cycle(1'b0, 1'b0, 16'h0000, 4'hF, 4'h0);
    chk("midreset_an_n", {12'h000, an_n}, 16'h000F);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0000, 4'hF, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one 4-bit hex-to-segment decoder across all digits: presents one nibble per time slot on `bin` and asserts the matching active-low anode.
- Double-buffers the display value so updates land only on frame boundaries.
- Inserts a blanking interval before each digit to prevent ghosting.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- DIGIT_CYCLES, 50000, clk cycles per digit slot including blanking.
- BLANK_CYCLES, 500, clk cycles per slot with all anodes off; constraint 1 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- value  input  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 least significant.
- load  input  1  one-cycle strobe; captures value into the pending buffer.
- digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- dp  input  NUM_DIGITS  decimal-point request per digit, active-high.
- bin  output  4  nibble to the shared hex-to-segment decoder.
- an_n  output  NUM_DIGITS  anode drives, active-low, at most one low at any time.
- dp_n  output  1  decimal-point segment, active-low.
- frame_tick  output  1  one-cycle pulse when digit index wraps to 0.

Behaviour:
- Reset: clock/reset are one clk, synchronous active-low reset rst_n; all state sampled on the rising edge of clk with rst_n low.
  - Reset values: an_n all 1, dp_n=1, bin=0, frame_tick=0, slot counter=0, digit index=0, state=BLANK, pending=0, active=0.
  - Reset mid-slot aborts immediately; the first post-reset slot is digit 0 starting in BLANK.
- Slot counter: counts 0..DIGIT_CYCLES-1, then wraps to 0 and advances the digit index.
  - Digit index wraps from NUM_DIGITS-1 to 0.
  - frame_tick=1 for exactly the cycle in which index becomes 0; it does not pulse on the reset exit.
- FSM, two states:
  - BLANK: an_n all 1, dp_n=1.
    - bin loads active[idx] on entry (registered) and is held for the whole slot.
    - Go to DRIVE when the slot counter reaches BLANK_CYCLES-1.
  - DRIVE: an_n[idx]=0 if digit_en[idx]=1, else all 1; dp_n=~dp[idx] gated by the same enable.
    - At slot end, return to BLANK with the next index.
  - digit_en and dp are sampled live each cycle (not buffered).
  - A disabled digit still consumes its slot, so frame rate is constant at NUM_DIGITS*DIGIT_CYCLES.
- All outputs are registered; an_n changes one cycle after the counter condition.
  - bin is stable at least BLANK_CYCLES before its anode goes low.
- Buffering:
  - load=1 copies value into pending.
  - At each frame boundary (index wrap to 0) active <= pending.
  - If load coincides with a frame boundary, active <= value directly and pending <= value.
  - Multiple loads within a frame: last one wins.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i is treated as disabled when it is 0 and every more-significant digit is 0.
  - Evaluated on the active buffer at frame boundary.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A digit with dp[i]=1 is never suppressed, and neither is any digit below it.
- Undefined: all digits displayed per digit_en only; no extra logic.

Decomposition:
- Package seg_scan_pkg:
  - localparams for nibble width (4), anode-off and segment-off levels (1).
  - FSM state typedef {BLANK, DRIVE}.
  - Function computing index width clog2(NUM_DIGITS).
- One sub-module: seg_scan_timer, the slot counter.
  - Outputs: slot_end pulse, blank_done pulse.
  - Keeps DIGIT_CYCLES/BLANK_CYCLES arithmetic out of the FSM.
- The decoder itself stays outside this block.

Test Plan:
- Bench parameters: NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Scenario 1, reset: hold rst_n=0 3 cycles, release -> an_n=4'b1111, dp_n=1, bin=0 during reset. First an_n=4'b1110 appears exactly 2 cycles after the BLANK phase begins; frame_tick every 32 cycles.
- Scenario 2, scan order: load value=16'h1A2F with digit_en=4'hF -> bin sequence F,2,A,1 per frame. an_n sequence 1110,1101,1011,0111. All-ones for 2 cycles between each.
- Scenario 3, double buffer: load 16'h1234 mid-frame -> display keeps the old value until the next frame_tick, then shows 4,3,2,1. Load coinciding with frame_tick -> new value shown in that same frame.
- Scenario 4, enables/dp: digit_en=4'b0101, dp=4'b0100 -> an_n never 1101 or 0111; slots 1 and 3 all-ones. dp_n=0 only during digit 2 DRIVE.
- Scenario 5, reset mid-DRIVE: assert rst_n=0 while an_n=1011 -> next cycle an_n=1111, index 0, active=0.
- Scenario 6, with SEG_SCAN_LZ_BLANK_EN: value=16'h0070 -> digits 3,2 dark, digits 1,0 lit.
  - value=16'h0000 -> only digit 0 lit.
  - value=16'h0070 with dp=4'b1000 -> all four lit.
